// File: rtl/odd_ctr_pkg.sv
// Shared types and constants for the odd up/down counter sweep controller.
// Latency: none (declarations only).
// Backpressure: not applicable.
package odd_ctr_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        UP,
        DOWN,
        DONE
    } state_t;

    // The counter parks on the smallest odd value and moves one odd step per clock.
    localparam int ODD_MIN = 1;
    localparam int STEP    = 2;

    function automatic logic is_odd(input int unsigned v);
        return (v % 2) == 1;
    endfunction

endpackage

// File: rtl/sweep_cmd_reg.sv
// Sweep command register: checks an incoming command, latches bounds, counts reversals.
// Latency: cmd_ok is combinational; lo/hi/rev_left update on the edge after load/dec.
// Backpressure: none here; the controller only pulses load while it is idle.
module sweep_cmd_reg
    import odd_ctr_pkg::*;
#(
    parameter int W  = 4,
    parameter int RW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          dec,
    input  logic [W-1:0]  cmd_lo,
    input  logic [W-1:0]  cmd_hi,
    input  logic [RW-1:0] cmd_rev,
    output logic          cmd_ok,
    output logic [W-1:0]  lo,
    output logic [W-1:0]  hi,
    output logic [RW-1:0] rev_left
);

    // Bounds must be odd with at least one step between them; comparing at W+1 bits
    // keeps lo+2 from wrapping. hi <= 2^W-1 holds by construction of the port width.
    always_comb begin
        cmd_ok = is_odd(32'(cmd_lo)) && is_odd(32'(cmd_hi))
              && (cmd_lo >= W'(ODD_MIN))
              && ({1'b0, cmd_hi} >= ({1'b0, cmd_lo} + (W+1)'(STEP)));
    end

    // Capture the command on accept; each turn consumes one reversal.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lo       <= W'(ODD_MIN);
            hi       <= W'(ODD_MIN);
            rev_left <= '0;
        end else if (load) begin
            lo       <= cmd_lo;
            hi       <= cmd_hi;
            rev_left <= cmd_rev;
        end else if (dec && (rev_left != '0)) begin
            rev_left <= rev_left - RW'(1);
        end
    end

endmodule

// File: rtl/odd_counter_sweep_ctrl.sv
// Sweep sequencer driving odd_up_down_counter direction/reset between two odd bounds.
// Latency: all outputs registered; counter is released 2 edges after command accept.
// Backpressure: cmd_ready is low from the edge after accept until the cycle after done.
module odd_counter_sweep_ctrl
    import odd_ctr_pkg::*;
#(
    parameter int W  = 4,
    parameter int RW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [W-1:0]  cmd_lo,
    input  logic [W-1:0]  cmd_hi,
    input  logic [RW-1:0] cmd_rev,
    input  logic          abort,
    input  logic [W-1:0]  count,
    output logic          Y,
    output logic          cnt_reset,
    output logic          busy,
    output logic          done,
    output logic          aborted,
    output logic          err,
    output logic [RW-1:0] rev_left
);

    state_t         state;
    state_t         nxt_state;
    logic           nxt_y;
    logic           nxt_cnt_reset;
    logic           nxt_aborted;
    logic           nxt_err;
    logic           load;
    logic           dec;
    logic           cmd_ok;
    logic [W-1:0]   lo;
    logic [W-1:0]   hi;
    logic           at_hi_turn;
    logic           at_lo_turn;

    sweep_cmd_reg #(
        .W  (W),
        .RW (RW)
    ) u_cmd (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .dec      (dec),
        .cmd_lo   (cmd_lo),
        .cmd_hi   (cmd_hi),
        .cmd_rev  (cmd_rev),
        .cmd_ok   (cmd_ok),
        .lo       (lo),
        .hi       (hi),
        .rev_left (rev_left)
    );

    // Turn one step early: Y is registered, so the counter lands exactly on the bound.
    always_comb begin
        at_hi_turn = (count == (hi - W'(STEP)));
        at_lo_turn = (count == (lo + W'(STEP)));
    end

    // Next-state and next-output decode; abort takes priority over any turn.
    always_comb begin
        nxt_state     = state;
        nxt_y         = Y;
        nxt_cnt_reset = cnt_reset;
        nxt_aborted   = aborted;
        nxt_err       = 1'b0;
        load          = 1'b0;
        dec           = 1'b0;
        case (state)
            IDLE: begin
                // Counter stays parked at 1 while idle.
                nxt_y         = 1'b1;
                nxt_cnt_reset = 1'b0;
                if (cmd_valid && cmd_ready) begin
                    nxt_aborted = 1'b0;
                    if (cmd_ok) begin
                        load      = 1'b1;
                        nxt_state = INIT;
                    end else begin
                        nxt_err = 1'b1;
                    end
                end
            end
            INIT: begin
                if (abort) begin
                    nxt_cnt_reset = 1'b0;
                    nxt_aborted   = 1'b1;
                    nxt_state     = DONE;
                end else begin
                    nxt_cnt_reset = 1'b1;
                    nxt_y         = 1'b1;
                    nxt_state     = UP;
                end
            end
            UP: begin
                if (abort) begin
                    nxt_cnt_reset = 1'b0;
                    nxt_aborted   = 1'b1;
                    nxt_state     = DONE;
                end else if (at_hi_turn && Y) begin
                    if (rev_left != '0) begin
                        nxt_y     = 1'b0;
                        dec       = 1'b1;
                        nxt_state = DOWN;
                    end else begin
                        nxt_cnt_reset = 1'b0;
                        nxt_state     = DONE;
                    end
                end
            end
            DOWN: begin
                if (abort) begin
                    nxt_cnt_reset = 1'b0;
                    nxt_aborted   = 1'b1;
                    nxt_state     = DONE;
                end else if (at_lo_turn && !Y) begin
                    if (rev_left != '0) begin
                        nxt_y     = 1'b1;
                        dec       = 1'b1;
                        nxt_state = UP;
                    end else begin
                        nxt_cnt_reset = 1'b0;
                        nxt_state     = DONE;
                    end
                end
            end
            DONE: begin
                nxt_y         = 1'b1;
                nxt_cnt_reset = 1'b0;
                nxt_state     = IDLE;
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase
    end

    // State and output registers; status flags are decoded from the next state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            Y         <= 1'b1;
            cnt_reset <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            err       <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            state     <= nxt_state;
            Y         <= nxt_y;
            cnt_reset <= nxt_cnt_reset;
            busy      <= (nxt_state == INIT) || (nxt_state == UP) || (nxt_state == DOWN);
            done      <= (nxt_state == DONE);
            aborted   <= nxt_aborted;
            err       <= nxt_err;
            cmd_ready <= (nxt_state == IDLE);
        end
    end

endmodule
